// File: rtl/fifo_write.sv
// Write-side framer for the packet FIFO: windows the receive byte stream per prb frame and
// pushes {last, byte} words, holding one byte back so the final word can carry the end tag.
module fifo_write #(
    parameter int DW         = 8,
    parameter int SKIP_BYTES = 0,
    parameter int MAX_BYTES  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prb,
    input  logic          DM,
    input  logic [DW-1:0] din,
    input  logic          fifo_full,
    output logic          fifo_wrreq,
    output logic [DW:0]   fifo_data,
    output logic          pkt_done,
    output logic          pkt_drop,
    output logic [7:0]    pkt_len
);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        DROP
    } state_t;

    state_t        state;
    logic          prb_d;
    logic [7:0]    beat_cnt;
    logic [7:0]    word_cnt;
    logic          hold_vld;
    logic [DW-1:0] hold;
    logic          done_pend;
    logic [7:0]    len_pend;

    logic start;
    logic stop;
    logic beat;
    logic active;
    logic in_window;
    logic end_pkt;
    logic push_req;
    logic abort;

    // beat_cnt is 0 whenever the FSM sits in IDLE, so it is the index of a start-cycle beat too
    always_comb begin
        start     = prb & ~prb_d;
        stop      = ~prb & prb_d;
        beat      = DM & prb;
        active    = (state == CAPT) || ((state == IDLE) && start);
        in_window = (int'(beat_cnt) >= SKIP_BYTES) &&
                    (int'(beat_cnt) < SKIP_BYTES + MAX_BYTES) &&
                    (int'(word_cnt) < MAX_BYTES);
        end_pkt   = (state == CAPT) && stop;
        push_req  = hold_vld && ((active && beat && in_window) || end_pkt);
        abort     = push_req && fifo_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prb_d      <= 1'b1;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            hold_vld   <= 1'b0;
            hold       <= '0;
            done_pend  <= 1'b0;
            len_pend   <= '0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            pkt_done   <= 1'b0;
            pkt_drop   <= 1'b0;
            pkt_len    <= '0;
        end else begin
            prb_d      <= prb;
            fifo_wrreq <= 1'b0;
            pkt_drop   <= abort;
            pkt_done   <= done_pend;
            done_pend  <= 1'b0;

            if (done_pend) begin
                pkt_len <= len_pend;
            end

            if (push_req && !fifo_full) begin
                fifo_wrreq <= 1'b1;
                fifo_data  <= {end_pkt, hold};
            end

            unique case (state)
                IDLE: if (start) state <= CAPT;
                CAPT: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (abort) begin
                        state <= DROP;
                    end
                end
                DROP: if (stop) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (end_pkt && !abort) begin
                // an empty window completes immediately; otherwise wait for the tagged push
                if (hold_vld) begin
                    done_pend <= 1'b1;
                    len_pend  <= word_cnt;
                end else begin
                    pkt_done <= 1'b1;
                    pkt_len  <= '0;
                end
            end

            if (abort || end_pkt) begin
                beat_cnt <= '0;
                word_cnt <= '0;
                hold_vld <= 1'b0;
            end else if (active && beat) begin
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (in_window) begin
                    hold     <= din;
                    hold_vld <= 1'b1;
                    word_cnt <= word_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_write.sv
// Scoreboard bench for fifo_write: two instances (SKIP=0/MAX=64 and SKIP=2/MAX=4) share stimulus;
// a packet-level model queues timed expected events, a negedge monitor pops and compares them.
module tb_fifo_write;

    logic       clk = 1'b0;
    logic       rst;
    logic       prb;
    logic       dm;
    logic [7:0] din;
    logic       full0, full1;

    logic       wr0, wr1;
    logic [8:0] d0, d1;
    logic       done0, done1, drop0, drop1;
    logic [7:0] len0, len1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_write #(.DW(8), .SKIP_BYTES(0), .MAX_BYTES(64)) u0 (
        .clk(clk), .rst(rst), .prb(prb), .DM(dm), .din(din), .fifo_full(full0),
        .fifo_wrreq(wr0), .fifo_data(d0), .pkt_done(done0), .pkt_drop(drop0), .pkt_len(len0)
    );

    fifo_write #(.DW(8), .SKIP_BYTES(2), .MAX_BYTES(4)) u1 (
        .clk(clk), .rst(rst), .prb(prb), .DM(dm), .din(din), .fifo_full(full1),
        .fifo_wrreq(wr1), .fifo_data(d1), .pkt_done(done1), .pkt_drop(drop1), .pkt_len(len1)
    );

    // kind: 0 = push (val = {last,byte}), 1 = drop, 2 = done (val = pkt_len)
    typedef struct {
        int         cyc;
        int         kind;
        logic [8:0] val;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    bit         m_prev[2];
    bit         m_act[2];
    bit         m_drop[2];
    int         m_n[2];
    int         m_acc[2];
    logic [7:0] m_held[2];

    function automatic int sk(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int mx(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic int qsz(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic expect_ev(input int i, input int c, input int k, input logic [8:0] v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic purge(input int c);
        ev_t t[$];
        t = {};
        foreach (q0[j]) if (q0[j].cyc < c) t.push_back(q0[j]);
        q0 = t;
        t = {};
        foreach (q1[j]) if (q1[j].cyc < c) t.push_back(q1[j]);
        q1 = t;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 1'b1;
            m_act[i]  = 1'b0;
            m_drop[i] = 1'b0;
        end
    endtask

    // Window bytes are accepted in order; the newest accepted byte stays held back, so each
    // later acceptance pushes its predecessor and the frame end pushes the held byte as last.
    task automatic model_step(input int i, input bit p, input bit m, input logic [7:0] b,
                              input bit f, input int d);
        bit start, stop;
        int idx;
        start = p && !m_prev[i];
        stop  = !p && m_prev[i];
        m_prev[i] = p;
        if (m_drop[i]) begin
            if (stop) m_drop[i] = 1'b0;
            return;
        end
        if (!m_act[i]) begin
            if (!start) return;
            m_act[i] = 1'b1; m_n[i] = 0; m_acc[i] = 0;
        end
        if (stop) begin
            m_act[i] = 1'b0;
            if (m_acc[i] == 0) begin
                expect_ev(i, d + 1, 2, 9'd0);
            end else if (f) begin
                expect_ev(i, d + 1, 1, 9'd0);
            end else begin
                expect_ev(i, d + 1, 0, {1'b1, m_held[i]});
                expect_ev(i, d + 2, 2, 9'(m_acc[i]));
            end
        end else if (p && m) begin
            idx = m_n[i];
            if (m_n[i] < 255) m_n[i]++;
            if (idx >= sk(i) && idx < sk(i) + mx(i) && m_acc[i] < mx(i)) begin
                if (m_acc[i] > 0) begin
                    if (f) begin
                        expect_ev(i, d + 1, 1, 9'd0);
                        m_act[i]  = 1'b0;
                        m_drop[i] = 1'b1;
                        return;
                    end
                    expect_ev(i, d + 1, 0, {1'b0, m_held[i]});
                end
                m_held[i] = b;
                m_acc[i]++;
            end
        end
    endtask

    task automatic step(input bit r, input bit p, input bit m, input logic [7:0] b,
                        input bit f0, input bit f1);
        @(posedge clk);
        #1;
        rst = r; prb = p; dm = m; din = b; full0 = f0; full1 = f1;
        if (r) begin
            purge(cyc);
            model_reset();
        end else begin
            model_step(0, p, m, b, f0, cyc);
            model_step(1, p, m, b, f1, cyc);
        end
    endtask

    task automatic idle(input int n, input bit rnd_full);
        bit f;
        for (int j = 0; j < n; j++) begin
            f = rnd_full && ($urandom_range(3) == 0);
            step(0, 0, 1'($urandom_range(1)), 8'($urandom), f, f);
        end
    endtask

    // beat 0 always lands in the start cycle; full_at forces fifo_full on that beat's cycle
    task automatic packet(input int nbeats, input logic [7:0] base, input int gap_pct,
                          input int full_at, input bit rnd_full);
        int  k;
        bit  m, f;
        k = 0;
        if (nbeats == 0) begin
            repeat (1 + $urandom_range(4)) step(0, 1, 0, 8'($urandom), 0, 0);
            return;
        end
        while (k < nbeats) begin
            m = (k == 0) || ($urandom_range(99) >= gap_pct);
            f = (m && k == full_at) || (rnd_full && $urandom_range(11) == 0);
            step(0, 1, m, m ? 8'(int'(base) + k) : 8'($urandom), f, f);
            if (m) k++;
        end
    endtask

    task automatic mon(input int i, input logic wr, input logic [8:0] data, input logic drp,
                       input logic dn, input logic [7:0] len);
        ev_t e;
        while (qsz(i) > 0) begin
            e = qfront(i);
            if (e.cyc >= cyc) break;
            qpop(i);
            n_cmp++; n_err++;
            $display("FAIL u%0d missing_event kind=%0d: got nothing at cyc %0d, expected val %h",
                     i, e.kind, e.cyc, e.val);
        end
        for (int k = 0; k < 3; k++) begin
            logic       sig;
            logic [8:0] v;
            sig = (k == 0) ? wr : (k == 1) ? drp : dn;
            v   = (k == 0) ? data : (k == 2) ? {1'b0, len} : 9'd0;
            if (sig) begin
                n_cmp++;
                if (qsz(i) == 0) begin
                    n_err++;
                    $display("FAIL u%0d unexpected_event kind=%0d at cyc %0d: got val %h, expected none",
                             i, k, cyc, v);
                end else begin
                    e = qfront(i);
                    if (e.cyc != cyc || e.kind != k) begin
                        n_err++;
                        $display("FAIL u%0d event_order at cyc %0d: got kind=%0d val %h, expected kind=%0d at cyc %0d",
                                 i, cyc, k, v, e.kind, e.cyc);
                    end else begin
                        qpop(i);
                        if (e.val !== v) begin
                            n_err++;
                            $display("FAIL u%0d event_value kind=%0d at cyc %0d: got %h, expected %h",
                                     i, k, cyc, v, e.val);
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, wr0, d0, drop0, done0, len0);
        mon(1, wr1, d1, drop1, done1, len1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_len(input string nm, input int e0, input int e1);
        @(negedge clk);
        chk({nm, "_len0"}, int'(len0), e0);
        chk({nm, "_len1"}, int'(len1), e1);
    endtask

    initial begin
        rst = 1'b1; prb = 1'b0; dm = 1'b0; din = '0; full0 = 1'b0; full1 = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_wr0", int'(wr0), 0);     chk("rst_wr1", int'(wr1), 0);
        chk("rst_data0", int'(d0), 0);    chk("rst_data1", int'(d1), 0);
        chk("rst_done0", int'(done0), 0); chk("rst_done1", int'(done1), 0);
        chk("rst_drop0", int'(drop0), 0); chk("rst_drop1", int'(drop1), 0);
        chk("rst_len0", int'(len0), 0);   chk("rst_len1", int'(len1), 0);
        idle(2, 0);

        // contiguous 10-beat and 9-beat packets
        packet(10, 8'h01, 0, -1, 0); idle(4, 0); chk_len("pkt10", 10, 4);
        packet(9, 8'h10, 0, -1, 0);  idle(4, 0); chk_len("pkt9", 9, 4);

        // fifo_full on beat 3: u0 has pushed two words, u1 none; lengths must not change
        packet(6, 8'h30, 0, 3, 0); idle(4, 0); chk_len("drop", 9, 4);
        packet(5, 8'h40, 0, -1, 0); idle(4, 0); chk_len("after_drop", 5, 3);

        // frame with no qualified bytes
        repeat (5) step(0, 1, 0, 8'($urandom), 0, 0);
        idle(4, 0); chk_len("empty", 0, 0);

        // back-to-back frames with one low cycle between
        packet(4, 8'h60, 0, -1, 0); idle(1, 0);
        packet(3, 8'h70, 0, -1, 0); idle(4, 0); chk_len("b2b", 3, 1);

        // reset released while a frame is already running
        step(1, 1, 1, 8'hA0, 0, 0);
        step(1, 1, 1, 8'hA1, 0, 0);
        for (int j = 0; j < 4; j++) step(0, 1, 1, 8'(8'hA2 + j), 0, 0);
        idle(2, 0);
        packet(5, 8'h80, 0, -1, 0); idle(4, 0); chk_len("rst_release", 5, 3);

        // reset pulse in the middle of a frame
        for (int j = 0; j < 5; j++) step(0, 1, 1, 8'(8'h50 + j), 0, 0);
        step(1, 1, 1, 8'h55, 0, 0);
        @(negedge clk);
        chk("midrst_wr0", int'(wr0), 0);  chk("midrst_done0", int'(done0), 0);
        chk("midrst_drop0", int'(drop0), 0); chk("midrst_len0", int'(len0), 0);
        step(1, 1, 1, 8'h56, 0, 0);
        step(0, 1, 1, 8'h57, 0, 0);
        idle(3, 0);

        // beyond MAX_BYTES for both instances
        packet(70, 8'h00, 0, -1, 0); idle(4, 0); chk_len("long", 64, 4);

        for (int p = 0; p < 40; p++) begin
            packet($urandom_range(12), 8'($urandom), 30, -1, 1);
            idle(1 + $urandom_range(2), 1);
        end

        idle(6, 0);
        @(negedge clk);
        chk("leftover_q0", q0.size(), 0);
        chk("leftover_q1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
